dmem_responder: RTL and testbench

Data-memory responder on the core's load/store port. It accepts one request at a time from the RV32I core (address, write data, write strobe, funct3 size code) and inserts a configurable number of wait states. It then returns a single-cycle response carrying the sign/zero-extended load data or an error flag. It sits between the core's `dataaddr`/`writedata`/`memwrite` outputs and the `Top` level. It replaces the zero-latency memory model so the core's stall path can be exercised.

---
 rtl/dmem_responder.sv | 199 +++++++++++++++++++
 tb/tb_dmem_responder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the RV32I load/store port.
// Accepts one request at a time, waits WAIT_CYCLES cycles, then returns a one-cycle response.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        memwrite,
  input  logic [31:0] dataaddr,
  input  logic [31:0] writedata,
  input  logic [2:0]  funct3,
  output logic        rsp_valid,
  output logic [31:0] readdata,
  output logic        rsp_err
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT    = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wd_q, wd_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] readdata_q, readdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  // Request being resolved: with zero wait states RESP is entered on the
  // accept edge itself, so the live inputs must be used instead of the capture.
  logic        r_we;
  logic [31:0] r_addr, r_wd, r_off;
  logic [2:0]  r_f3;
  logic [AW-1:0] r_idx;
  logic        r_err;
  logic [31:0] ld_word, ld_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [3:0]  st_be;
  logic [31:0] st_data;
  logic        commit, mem_we;

  always_comb begin
    if (state_q == IDLE) begin
      r_we   = memwrite;
      r_addr = dataaddr;
      r_wd   = writedata;
      r_f3   = funct3;
    end else begin
      r_we   = we_q;
      r_addr = addr_q;
      r_wd   = wd_q;
      r_f3   = f3_q;
    end
  end

  // BASE_ADDR is word-aligned, so the low offset bits equal the low address bits.
  assign r_off = r_addr - BASE_ADDR;
  assign r_idx = r_off[AW+1:2];

  always_comb begin
    r_err = 1'b0;
    if ({1'b0, r_off} >= LIMIT) r_err = 1'b1;
    case (r_f3)
      3'd1, 3'd5:       if (r_off[0]) r_err = 1'b1;
      3'd2:             if (r_off[1:0] != 2'd0) r_err = 1'b1;
      3'd3, 3'd6, 3'd7: r_err = 1'b1;
      default:          ;
    endcase
    if (r_we && (r_f3 == 3'd4 || r_f3 == 3'd5)) r_err = 1'b1;
  end

  assign ld_word = mem_q[r_idx];

  always_comb begin
    case (r_off[1:0])
      2'd0:    ld_byte = ld_word[7:0];
      2'd1:    ld_byte = ld_word[15:8];
      2'd2:    ld_byte = ld_word[23:16];
      default: ld_byte = ld_word[31:24];
    endcase
    ld_half = r_off[1] ? ld_word[31:16] : ld_word[15:0];
    case (r_f3)
      3'd0:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    ld_data = {{16{ld_half[15]}}, ld_half};
      3'd4:    ld_data = {24'd0, ld_byte};
      3'd5:    ld_data = {16'd0, ld_half};
      default: ld_data = ld_word;
    endcase
  end

  always_comb begin
    case (r_f3[1:0])
      2'd0: begin
        st_be   = 4'b0001 << r_off[1:0];
        st_data = {4{r_wd[7:0]}};
      end
      2'd1: begin
        st_be   = r_off[1] ? 4'b1100 : 4'b0011;
        st_data = {2{r_wd[15:0]}};
      end
      default: begin
        st_be   = 4'b1111;
        st_data = r_wd;
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wd_d       = wd_q;
    f3_d       = f3_q;
    commit     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d   = memwrite;
          addr_d = dataaddr;
          wd_d   = writedata;
          f3_d   = funct3;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    readdata_d = readdata_q;
    rsp_err_d  = rsp_err_q;
    if (commit) begin
      readdata_d = (r_we || r_err) ? 32'd0 : ld_data;
      rsp_err_d  = r_err;
    end
  end

  assign mem_we = commit && r_we && !r_err;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      wd_q       <= 32'd0;
      f3_q       <= 3'd0;
      readdata_q <= 32'd0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wd_q       <= wd_d;
      f3_q       <= f3_d;
      readdata_q <= readdata_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Storage is not reset; a reset edge only suppresses the pending write.
  always_ff @(posedge clk) begin
    if (rst && mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) mem_q[r_idx][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign readdata  = readdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with 0, 1 and 3 wait states.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        rv0, rv1, rv3;
  logic        memwrite;
  logic [31:0] dataaddr, writedata;
  logic [2:0]  funct3;
  logic        rdy0, rdy1, rdy3, rsp0, rsp1, rsp3, er0, er1, er3;
  logic [31:0] rd0, rd1, rd3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h2000), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .rst(rst), .req_valid(rv0), .req_ready(rdy0), .memwrite(memwrite),
    .dataaddr(dataaddr), .writedata(writedata), .funct3(funct3),
    .rsp_valid(rsp0), .readdata(rd0), .rsp_err(er0));

  dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h2000), .WAIT_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .req_valid(rv1), .req_ready(rdy1), .memwrite(memwrite),
    .dataaddr(dataaddr), .writedata(writedata), .funct3(funct3),
    .rsp_valid(rsp1), .readdata(rd1), .rsp_err(er1));

  dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h2000), .WAIT_CYCLES(3)) u3 (
    .clk(clk), .rst(rst), .req_valid(rv3), .req_ready(rdy3), .memwrite(memwrite),
    .dataaddr(dataaddr), .writedata(writedata), .funct3(funct3),
    .rsp_valid(rsp3), .readdata(rd3), .rsp_err(er3));

  function automatic logic rdy_of(int w);
    case (w) 0: return rdy0; 1: return rdy1; default: return rdy3; endcase
  endfunction
  function automatic logic rsp_of(int w);
    case (w) 0: return rsp0; 1: return rsp1; default: return rsp3; endcase
  endfunction
  function automatic logic [31:0] rd_of(int w);
    case (w) 0: return rd0; 1: return rd1; default: return rd3; endcase
  endfunction
  function automatic logic er_of(int w);
    case (w) 0: return er0; 1: return er1; default: return er3; endcase
  endfunction

  task automatic set_rv(input int w, input logic v);
    case (w) 0: rv0 = v; 1: rv1 = v; default: rv3 = v; endcase
  endtask

  // One transaction on instance w; lat = cycles from the accept cycle to the response cycle (0 = no response).
  task automatic xact(input int w, input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [2:0] f3, output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    for (int k = 0; k < 20 && !rdy_of(w); k++) @(negedge clk);
    memwrite = we; dataaddr = a; writedata = wd; funct3 = f3;
    set_rv(w, 1'b1);
    @(posedge clk);
    #1 set_rv(w, 1'b0);
    lat = 0; rd = 'x; er = 1'bx;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (rsp_of(w)) begin
        lat = n; rd = rd_of(w); er = er_of(w);
        break;
      end
    end
  endtask

  task automatic test_reset();
    int lat;
    rst = 1'b0;
    memwrite = 1'b1; dataaddr = 32'h2000; writedata = 32'hA5A5_A5A5; funct3 = 3'd2;
    rv1 = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (rsp1 !== 1'b0 || rdy1 !== 1'b1)
        begin errors++; $display("FAIL reset_hs rsp_valid=%b req_ready=%b exp 0/1", rsp1, rdy1); end
      checks++;
      if (rd1 !== 32'd0 || er1 !== 1'b0)
        begin errors++; $display("FAIL reset_out readdata=%h err=%b exp 0/0", rd1, er1); end
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rv1 = 1'b0;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (rsp1) begin lat = n; break; end
    end
    checks++;
    if (lat != 2) begin errors++; $display("FAIL reset_first_lat got %0d exp 2", lat); end
    checks++;
    if (er1 !== 1'b0 || rd1 !== 32'd0)
      begin errors++; $display("FAIL reset_first_rsp readdata=%h err=%b exp 0/0", rd1, er1); end
    @(negedge clk);
    checks++;
    if (rsp1 !== 1'b0) begin errors++; $display("FAIL reset_pulse_width rsp_valid=%b exp 0", rsp1); end
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic er; int lat;
    logic [31:0] la[5], le[5];
    logic [2:0]  lf[5];
    la = '{32'h2005, 32'h2005, 32'h2006, 32'h2006, 32'h2004};
    lf = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
    le = '{32'hFFFF_FFBE, 32'h0000_00BE, 32'hFFFF_DEAD, 32'h0000_DEAD, 32'hDEAD_BEEF};
    xact(0, 1'b1, 32'h2004, 32'hDEAD_BEEF, 3'd2, rd, er, lat);
    checks++;
    if (rd !== 32'd0 || er !== 1'b0 || lat != 1)
      begin errors++; $display("FAIL sw_w0 readdata=%h err=%b lat=%0d exp 0/0/1", rd, er, lat); end
    for (int i = 0; i < 5; i++) begin
      xact(0, 1'b0, la[i], 32'd0, lf[i], rd, er, lat);
      checks++;
      if (rd !== le[i] || er !== 1'b0 || lat != 1)
        begin errors++; $display("FAIL load%0d readdata=%h err=%b lat=%0d exp %h/0/1", i, rd, er, lat, le[i]); end
    end
  endtask

  task automatic test_partial();
    logic [31:0] rd; logic er; int lat;
    xact(0, 1'b1, 32'h2000, 32'h0000_0000, 3'd2, rd, er, lat);
    xact(0, 1'b1, 32'h2003, 32'hFFFF_FF12, 3'd0, rd, er, lat);
    checks++;
    if (er !== 1'b0) begin errors++; $display("FAIL sb_err got %b exp 0", er); end
    xact(0, 1'b1, 32'h2000, 32'hFFFF_3456, 3'd1, rd, er, lat);
    checks++;
    if (er !== 1'b0) begin errors++; $display("FAIL sh_err got %b exp 0", er); end
    xact(0, 1'b0, 32'h2000, 32'd0, 3'd2, rd, er, lat);
    checks++;
    if (rd !== 32'h1200_3456 || er !== 1'b0)
      begin errors++; $display("FAIL partial_lw readdata=%h err=%b exp 12003456/0", rd, er); end
  endtask

  task automatic test_faults();
    logic [31:0] rd; logic er; int lat;
    logic        fw[11], fe[11];
    logic [31:0] fa[11], fd[11], fx[11];
    logic [2:0]  ff[11];
    fw = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    fa = '{32'h2002, 32'h2001, 32'h1FFF, 32'h3000, 32'h2000, 32'h2001,
           32'h2000, 32'h2000, 32'h2FFC, 32'h2FFC, 32'h2FFE};
    fd = '{32'd0, 32'd0, 32'h0000_0077, 32'd0, 32'd0, 32'h1111_1111,
           32'hFFFF_FFFF, 32'd0, 32'h0BAD_CAFE, 32'd0, 32'd0};
    ff = '{3'd2, 3'd1, 3'd0, 3'd2, 3'd3, 3'd2, 3'd4, 3'd2, 3'd2, 3'd2, 3'd5};
    fe = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    fx = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
           32'h1200_3456, 32'd0, 32'h0BAD_CAFE, 32'h0000_0BAD};
    for (int i = 0; i < 11; i++) begin
      xact(0, fw[i], fa[i], fd[i], ff[i], rd, er, lat);
      checks++;
      if (rd !== fx[i] || er !== fe[i] || lat != 1)
        begin errors++; $display("FAIL fault%0d readdata=%h err=%b lat=%0d exp %h/%b/1", i, rd, er, lat, fx[i], fe[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int lat;
    int acc[3], rsp[3];
    int nacc = 0, nrsp = 0, cyc = 0;
    memwrite = 1'b1; dataaddr = 32'h2010; writedata = 32'h1357_2468; funct3 = 3'd2;
    rv3 = 1'b0;
    for (int i = 0; i < 40 && nrsp < 3; i++) begin
      @(negedge clk);
      cyc++;
      if (rsp3) begin rsp[nrsp] = cyc; nrsp++; end
      if (rdy3) begin
        if (nacc < 3) begin rv3 = 1'b1; acc[nacc] = cyc; nacc++; end
        else rv3 = 1'b0;
      end
    end
    rv3 = 1'b0;
    checks++;
    if (nacc != 3 || nrsp != 3)
      begin errors++; $display("FAIL b2b_count accepts=%0d responses=%0d exp 3/3", nacc, nrsp); end
    else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rsp[i] - acc[i] != 4)
          begin errors++; $display("FAIL b2b_lat%0d got %0d exp 4", i, rsp[i] - acc[i]); end
      end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (acc[i+1] - acc[i] != 5)
          begin errors++; $display("FAIL b2b_gap%0d got %0d exp 5", i, acc[i+1] - acc[i]); end
      end
    end
    xact(3, 1'b0, 32'h2010, 32'd0, 3'd2, rd, er, lat);
    checks++;
    if (rd !== 32'h1357_2468 || er !== 1'b0 || lat != 4)
      begin errors++; $display("FAIL b2b_lw readdata=%h err=%b lat=%0d exp 13572468/0/4", rd, er, lat); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat;
    logic seen = 1'b0;
    @(negedge clk);
    memwrite = 1'b1; dataaddr = 32'h2010; writedata = 32'hCAFE_F00D; funct3 = 3'd2;
    rv3 = 1'b1;
    @(posedge clk);
    #1 rv3 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++;
    if (rdy3 !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b exp 1", rdy3); end
    if (rsp3) seen = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (rsp3) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_rsp got %b exp 0", seen); end
    xact(3, 1'b0, 32'h2010, 32'd0, 3'd2, rd, er, lat);
    checks++;
    if (rd !== 32'h1357_2468 || er !== 1'b0 || lat != 4)
      begin errors++; $display("FAIL midrst_lw readdata=%h err=%b lat=%0d exp 13572468/0/4", rd, er, lat); end
  endtask

  initial begin
    rst = 1'b0; rv0 = 1'b0; rv1 = 1'b0; rv3 = 1'b0;
    memwrite = 1'b0; dataaddr = 32'd0; writedata = 32'd0; funct3 = 3'd0;
    test_reset();
    test_store_load();
    test_partial();
    test_faults();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
